// File: rtl/sync_mc_fifo_if.sv
// Bus bundle for sync_mc_fifo: write/read requests, per-channel controls,
// status and error flags.
//   master: drives wen/wch/wdata, ren/rch, ptr_clr and the margins;
//           observes rdata/rvalid, status, sticky errors and rlevel.
//   slave : the FIFO side of the same signals.
interface sync_mc_fifo_if #(
   parameter int unsigned DSIZE = 32,
   parameter int unsigned ASIZE = 4,
   parameter int unsigned NCH   = 4,
   parameter int unsigned CSIZE = 2
);
   logic             wen;
   logic [CSIZE-1:0] wch;
   logic [DSIZE-1:0] wdata;
   logic             ren;
   logic [CSIZE-1:0] rch;
   logic [DSIZE-1:0] rdata;
   logic             rvalid;
   logic [NCH-1:0]   ptr_clr;
   logic [ASIZE-1:0] near_full_mrgn;
   logic [ASIZE-1:0] near_empty_mrgn;
   logic [NCH-1:0]   full;
   logic [NCH-1:0]   near_full;
   logic [NCH-1:0]   empty;
   logic [NCH-1:0]   near_empty;
   logic [NCH-1:0]   over_flow;
   logic [NCH-1:0]   under_flow;
   logic [ASIZE:0]   rlevel;

   modport master (
      output wen, wch, wdata, ren, rch, ptr_clr, near_full_mrgn, near_empty_mrgn,
      input  rdata, rvalid, full, near_full, empty, near_empty, over_flow,
             under_flow, rlevel
   );

   modport slave (
      input  wen, wch, wdata, ren, rch, ptr_clr, near_full_mrgn, near_empty_mrgn,
      output rdata, rvalid, full, near_full, empty, near_empty, over_flow,
             under_flow, rlevel
   );
endinterface

// File: rtl/sync_mc_fifo.sv
// Multi-channel synchronous FIFO: NCH independent queues of 2^ASIZE words
// sharing one storage array addressed {channel, pointer}.
//   clk, rst_n : single clock, async active-low reset
//   bus        : sync_mc_fifo_if slave port (requests, controls, status,
//                sticky over/under-flow, rlevel of channel rch)
// FWFT=0 gives a registered read (rvalid one cycle after an accepted ren);
// FWFT=1 presents the head word of channel rch combinationally.
module sync_mc_fifo #(
   parameter int unsigned DSIZE = 32,
   parameter int unsigned ASIZE = 4,
   parameter int unsigned NCH   = 4,
   parameter int unsigned CSIZE = 2,
   parameter int unsigned FWFT  = 0
) (
   input logic           clk,
   input logic           rst_n,
   sync_mc_fifo_if.slave bus
);
   localparam int unsigned DEPTH = 1 << ASIZE;
   localparam int unsigned CW    = ASIZE + 1;
   localparam int unsigned AW    = CSIZE + ASIZE;

   logic [DSIZE-1:0] mem_q [NCH*DEPTH];
   logic [ASIZE-1:0] wptr_q [NCH];
   logic [ASIZE-1:0] wptr_d [NCH];
   logic [ASIZE-1:0] rptr_q [NCH];
   logic [ASIZE-1:0] rptr_d [NCH];
   logic [CW-1:0]    cnt_q  [NCH];
   logic [CW-1:0]    cnt_d  [NCH];
   logic [NCH-1:0]   ovf_q, ovf_d, unf_q, unf_d;
   logic [NCH-1:0]   full_c, empty_c, nfull_c, nempty_c;

   logic             wch_ok, rch_ok;
   logic [CSIZE-1:0] wch_s, rch_s;
   logic             w_req, r_req, w_acc, r_acc, w_ovf, r_unf;
   logic [AW-1:0]    waddr, raddr;
   logic [DSIZE-1:0] head;

   // Per-channel status from registered counts only
   always_comb begin
      for (int unsigned c = 0; c < NCH; c++) begin
         full_c[c]   = (cnt_q[c] == CW'(DEPTH));
         empty_c[c]  = (cnt_q[c] == '0);
         nfull_c[c]  = (cnt_q[c] >= (CW'(DEPTH) - {1'b0, bus.near_full_mrgn}));
         nempty_c[c] = (cnt_q[c] <= {1'b0, bus.near_empty_mrgn});
      end
   end

   // Out-of-range channel selects are steered to 0 and masked by *_ok
   assign wch_ok = (32'(bus.wch) < NCH);
   assign rch_ok = (32'(bus.rch) < NCH);
   assign wch_s  = wch_ok ? bus.wch : '0;
   assign rch_s  = rch_ok ? bus.rch : '0;

   // A cleared channel silently drops requests without raising errors
   assign w_req = bus.wen && wch_ok && !bus.ptr_clr[wch_s];
   assign r_req = bus.ren && rch_ok && !bus.ptr_clr[rch_s];
   assign w_acc = w_req && !full_c[wch_s];
   assign w_ovf = w_req &&  full_c[wch_s];
   assign r_acc = r_req && !empty_c[rch_s];
   assign r_unf = r_req &&  empty_c[rch_s];

   assign waddr = {wch_s, wptr_q[wch_s]};
   assign raddr = {rch_s, rptr_q[rch_s]};
   assign head  = mem_q[raddr];

   // Next-state for pointers, counts and sticky flags
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      for (int unsigned c = 0; c < NCH; c++) begin
         wptr_d[c] = wptr_q[c];
         rptr_d[c] = rptr_q[c];
         cnt_d[c]  = cnt_q[c];
      end
      for (int unsigned c = 0; c < NCH; c++) begin
         if (bus.ptr_clr[c]) begin
            wptr_d[c] = '0;
            rptr_d[c] = '0;
            cnt_d[c]  = '0;
            ovf_d[c]  = 1'b0;
            unf_d[c]  = 1'b0;
         end else begin
            if (w_acc && (wch_s == CSIZE'(c))) wptr_d[c] = wptr_q[c] + ASIZE'(1);
            if (r_acc && (rch_s == CSIZE'(c))) rptr_d[c] = rptr_q[c] + ASIZE'(1);
            cnt_d[c] = cnt_q[c] + CW'(w_acc && (wch_s == CSIZE'(c)))
                                - CW'(r_acc && (rch_s == CSIZE'(c)));
            if (w_ovf && (wch_s == CSIZE'(c))) ovf_d[c] = 1'b1;
            if (r_unf && (rch_s == CSIZE'(c))) unf_d[c] = 1'b1;
         end
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         for (int unsigned c = 0; c < NCH; c++) begin
            wptr_q[c] <= wptr_d[c];
            rptr_q[c] <= rptr_d[c];
            cnt_q[c]  <= cnt_d[c];
         end
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (w_acc) mem_q[waddr] <= bus.wdata;
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [DSIZE-1:0] rdata_q;
         logic             rvalid_q;

         // rdata holds its last value between accepted reads
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= r_acc;
               if (r_acc) rdata_q <= head;
            end
         end

         assign bus.rdata  = rdata_q;
         assign bus.rvalid = rvalid_q;
      end else begin : g_fwft_read
         assign bus.rdata  = head;
         assign bus.rvalid = rch_ok && !empty_c[rch_s];
      end
   endgenerate

   assign bus.full       = full_c;
   assign bus.empty      = empty_c;
   assign bus.near_full  = nfull_c;
   assign bus.near_empty = nempty_c;
   assign bus.over_flow  = ovf_q;
   assign bus.under_flow = unf_q;
   assign bus.rlevel     = rch_ok ? cnt_q[rch_s] : '0;
endmodule

// File: tb/tb_sync_mc_fifo.sv
// Scoreboard bench for sync_mc_fifo (defaults, FWFT=0). A queue-per-channel
// model tracks contents and sticky flags; accepted reads push the expected
// word onto exp_q, and an independent monitor pops it when rvalid appears.
module tb_sync_mc_fifo;
   localparam int unsigned DSIZE = 32;
   localparam int unsigned ASIZE = 4;
   localparam int unsigned NCH   = 4;
   localparam int unsigned CSIZE = 2;
   localparam int          DEPTH = 16;

   typedef logic [DSIZE-1:0] dq_t[$];

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sync_mc_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .NCH(NCH), .CSIZE(CSIZE)) bus ();

   sync_mc_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .NCH(NCH), .CSIZE(CSIZE), .FWFT(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // reference model
   dq_t              mq [NCH];
   logic [NCH-1:0]   ovf_m, unf_m;
   logic [DSIZE-1:0] exp_q[$];
   logic [DSIZE-1:0] last_rdata;
   int               nfm, nem;
   int               n_cmp = 0;
   int               n_bad = 0;
   bit               started = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < NCH; c++) mq[c].delete();
      ovf_m = '0;
      unf_m = '0;
      exp_q.delete();
      last_rdata = '0;
   endtask

   task automatic check_status(input int rc);
      logic [NCH-1:0] ef, ee, enf, ene;
      for (int c = 0; c < NCH; c++) begin
         ef[c]  = (mq[c].size() == DEPTH);
         ee[c]  = (mq[c].size() == 0);
         enf[c] = (mq[c].size() >= DEPTH - nfm);
         ene[c] = (mq[c].size() <= nem);
      end
      chk("full",       64'(bus.full),       64'(ef));
      chk("empty",      64'(bus.empty),      64'(ee));
      chk("near_full",  64'(bus.near_full),  64'(enf));
      chk("near_empty", 64'(bus.near_empty), 64'(ene));
      chk("over_flow",  64'(bus.over_flow),  64'(ovf_m));
      chk("under_flow", 64'(bus.under_flow), 64'(unf_m));
      chk("rlevel",     64'(bus.rlevel),     64'(mq[rc].size()));
   endtask

   // One clock: drive just after a falling edge, check pre-edge status,
   // advance the model across the rising edge, wait for the next fall.
   task automatic step(input bit w, input int wc, input logic [DSIZE-1:0] wd,
                       input bit r, input int rc, input logic [NCH-1:0] clr);
      bit wfull, rempty;
      bus.wen     = w;
      bus.wch     = CSIZE'(wc);
      bus.wdata   = wd;
      bus.ren     = r;
      bus.rch     = CSIZE'(rc);
      bus.ptr_clr = clr;
      bus.near_full_mrgn  = ASIZE'(nfm);
      bus.near_empty_mrgn = ASIZE'(nem);
      #1;
      check_status(rc);
      wfull  = (mq[wc].size() == DEPTH);
      rempty = (mq[rc].size() == 0);
      if (w && !clr[wc]) begin
         if (wfull) ovf_m[wc] = 1'b1;
         else       mq[wc].push_back(wd);
      end
      if (r && !clr[rc]) begin
         if (rempty) unf_m[rc] = 1'b1;
         else        exp_q.push_back(mq[rc].pop_front());
      end
      for (int c = 0; c < NCH; c++) begin
         if (clr[c]) begin
            mq[c].delete();
            ovf_m[c] = 1'b0;
            unf_m[c] = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 0, '0, 1'b0, 0, '0);
   endtask

   // Asynchronous reset pulse in the middle of a cycle
   task automatic do_reset();
      bus.wen = 1'b0;
      bus.ren = 1'b0;
      bus.ptr_clr = '0;
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
      chk("rst_rdata",  64'(bus.rdata),  64'd0);
      chk("rst_empty",  64'(bus.empty),  64'hF);
      chk("rst_full",   64'(bus.full),   64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: decoupled from stimulus, compares whenever the DUT presents data
   always @(negedge clk) begin
      if (started) begin
         if (bus.rvalid) begin
            if (exp_q.size() == 0) begin
               chk("rvalid_unexpected", 64'd1, 64'd0);
            end else begin
               logic [DSIZE-1:0] e;
               e = exp_q.pop_front();
               chk("rdata", 64'(bus.rdata), 64'(e));
               last_rdata = e;
            end
         end else begin
            if (exp_q.size() != 0) begin
               chk("rvalid_missing", 64'd0, 64'd1);
               void'(exp_q.pop_front());
            end
            chk("rdata_hold", 64'(bus.rdata), 64'(last_rdata));
         end
      end
   end

   initial begin
      bus.wen = 1'b0; bus.wch = '0; bus.wdata = '0;
      bus.ren = 1'b0; bus.rch = '0; bus.ptr_clr = '0;
      nfm = 3; nem = 2;
      bus.near_full_mrgn  = ASIZE'(nfm);
      bus.near_empty_mrgn = ASIZE'(nem);
      model_clear();
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      @(negedge clk);
      chk("init_rvalid", 64'(bus.rvalid), 64'd0);
      chk("init_rdata",  64'(bus.rdata),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      started = 1'b1;
      idle();

      // Fill ch1 to full, then one more write overflows
      for (int i = 0; i < 17; i++) step(1'b1, 1, $urandom, 1'b0, 1, '0);
      idle();
      for (int i = 0; i < 3; i++) step(1'b0, 0, '0, 1'b1, 1, '0);

      // Near-flag thresholds on ch0 (margins 3/2)
      for (int i = 0; i < 16; i++) step(1'b1, 0, $urandom, 1'b0, 0, '0);
      idle();

      // Registered read of 0xA5 on ch2, then underflow
      step(1'b1, 2, 32'hA5, 1'b0, 2, '0);
      step(1'b0, 0, '0, 1'b1, 2, '0);
      step(1'b0, 0, '0, 1'b1, 2, '0);
      idle();
      idle();

      // Full ch3 with simultaneous write+read: read wins, write overflows
      for (int i = 0; i < 16; i++) step(1'b1, 3, $urandom, 1'b0, 3, '0);
      step(1'b1, 3, 32'hDEAD_BEEF, 1'b1, 3, '0);
      idle();

      // ptr_clr on ch0 beats a same-cycle write; ch1 untouched
      step(1'b0, 0, '0, 1'b0, 0, 4'b0001);
      for (int i = 0; i < 5; i++) step(1'b1, 0, $urandom, 1'b0, 0, '0);
      step(1'b1, 0, 32'h1234_5678, 1'b0, 0, 4'b0001);
      idle();
      for (int i = 0; i < 4; i++) step(1'b0, 0, '0, 1'b1, 1, '0);

      // Wrap-around on ch1 with interleaved reads, then reset mid-stream
      step(1'b0, 0, '0, 1'b0, 1, 4'b0010);
      step(1'b1, 1, $urandom, 1'b0, 1, '0);
      for (int i = 0; i < 19; i++) step(1'b1, 1, $urandom, 1'b1, 1, '0);
      step(1'b0, 0, '0, 1'b1, 1, '0);
      for (int i = 0; i < 3; i++) step(1'b1, 1, $urandom, 1'b0, 1, '0);
      do_reset();
      idle();
      step(1'b1, 3, 32'h0BAD_F00D, 1'b0, 3, '0);
      step(1'b0, 0, '0, 1'b1, 3, '0);
      idle();

      // Randomised traffic across channels, margins and clears
      for (int i = 0; i < 800; i++) begin
         bit w, r;
         logic [NCH-1:0] clr;
         if (i % 100 == 0) begin
            nfm = int'($urandom_range(0, DEPTH - 1));
            nem = int'($urandom_range(0, DEPTH - 1));
         end
         w   = ($urandom_range(0, 99) < 55);
         r   = ($urandom_range(0, 99) < 45);
         clr = ($urandom_range(0, 99) < 3) ? NCH'(1 << $urandom_range(0, NCH - 1)) : '0;
         if (i == 400) do_reset();
         step(w, int'($urandom_range(0, NCH - 1)), $urandom,
              r, int'($urandom_range(0, NCH - 1)), clr);
      end
      idle();
      idle();
      chk("exp_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
